pipeline_stall_ctrl: RTL and testbench

Stall/flush controller for the RV32IM 5-stage pipeline. It covers the hazards that EX/MEM and MEM/WB forwarding cannot resolve: load-use dependencies, the multi-cycle DIV/REM sequence in EX, and taken-branch/jump redirects. It drives the enable and flush controls of the IF/ID, ID/EX and EX/MEM registers and keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_stall_ctrl_if.sv | 33 +++
 rtl/pipeline_stall_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-control bundle between the RV32IM pipeline datapath and its stall/flush controller.
// The datapath (master) reports hazard sources; the controller (slave) returns the stall and flush controls.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             MemReadE;
    logic [4:0]       RD_E;
    logic [4:0]       Rs1_D;
    logic [4:0]       Rs2_D;
    logic             UseRs1D;
    logic             UseRs2D;
    logic             IsDivE;
    logic             PCSrcE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             DivBusy;
    logic             DivDone;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output MemReadE, RD_E, Rs1_D, Rs2_D, UseRs1D, UseRs2D, IsDivE, PCSrcE,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM, DivBusy, DivDone, StallCount
    );

    modport slave (
        input  MemReadE, RD_E, Rs1_D, Rs2_D, UseRs1D, UseRs2D, IsDivE, PCSrcE,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM, DivBusy, DivDone, StallCount
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the RV32IM 5-stage pipeline: load-use bubbles, multi-cycle
// divide hold in EX, branch redirect flushes, and a saturating stall-cycle counter.
module pipeline_stall_ctrl #(
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_stall_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        DIV_BUSY = 1'b1
    } state_t;

    // The first divide cycle is spent in IDLE, so DIV_BUSY covers the remaining DIV_LATENCY-1.
    localparam logic [7:0]       DIV_LOAD  = 8'(DIV_LATENCY - 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [7:0]       div_cnt_r;
    logic [7:0]       div_cnt_nxt_s;
    logic             div_done_r;
    logic             div_done_nxt_s;
    logic [CNT_W-1:0] stall_count_r;

    logic             load_use_s;
    logic             div_stall_s;
    logic             stall_f_s;
    logic             stall_d_s;
    logic             stall_e_s;
    logic             flush_d_s;
    logic             flush_e_s;
    logic             flush_m_s;

    function automatic logic src_match(input logic use_src, input logic [4:0] rd, input logic [4:0] rs);
        return use_src & (rd == rs);
    endfunction

    // Divide sequencing plus priority resolution of divide stall, branch flush and load-use bubble.
    always_comb begin
        state_nxt_s    = state_r;
        div_cnt_nxt_s  = div_cnt_r;
        div_done_nxt_s = 1'b0;
        div_stall_s    = 1'b0;
        stall_f_s      = 1'b0;
        stall_d_s      = 1'b0;
        stall_e_s      = 1'b0;
        flush_d_s      = 1'b0;
        flush_e_s      = 1'b0;
        flush_m_s      = 1'b0;
        load_use_s     = bus.MemReadE & (bus.RD_E != 5'd0) &
                         (src_match(bus.UseRs1D, bus.RD_E, bus.Rs1_D) |
                          src_match(bus.UseRs2D, bus.RD_E, bus.Rs2_D));
        if (!rst) begin
            state_nxt_s   = IDLE;
            div_cnt_nxt_s = 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    // A just-finished divide still shows IsDivE while it leaves EX; do not restart on it.
                    if (bus.IsDivE && !bus.PCSrcE && !div_done_r) begin
                        div_stall_s   = 1'b1;
                        state_nxt_s   = DIV_BUSY;
                        div_cnt_nxt_s = DIV_LOAD;
                    end else begin
                        div_stall_s   = 1'b0;
                    end
                end
                DIV_BUSY: begin
                    div_stall_s = 1'b1;
                    if (div_cnt_r == 8'd0) begin
                        state_nxt_s    = IDLE;
                        div_done_nxt_s = 1'b1;
                    end else begin
                        div_cnt_nxt_s  = div_cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_nxt_s   = IDLE;
                    div_cnt_nxt_s = 8'd0;
                end
            endcase

            if (div_stall_s) begin
                stall_f_s = 1'b1;
                stall_d_s = 1'b1;
                stall_e_s = 1'b1;
                flush_m_s = 1'b1;
            end else if (bus.PCSrcE) begin
                flush_d_s = 1'b1;
                flush_e_s = 1'b1;
            end else if (load_use_s) begin
                stall_f_s = 1'b1;
                stall_d_s = 1'b1;
                flush_e_s = 1'b1;
            end else begin
                stall_f_s = 1'b0;
            end
        end
    end

    // Divide FSM state, remaining-cycle counter and the registered completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            div_cnt_r  <= 8'd0;
            div_done_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            div_cnt_r  <= div_cnt_nxt_s;
            div_done_r <= div_done_nxt_s;
        end
    end

    // Stall-cycle performance counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_r <= '0;
        end else if (stall_f_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_ONE;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign bus.StallF     = stall_f_s;
    assign bus.StallD     = stall_d_s;
    assign bus.StallE     = stall_e_s;
    assign bus.FlushD     = flush_d_s;
    assign bus.FlushE     = flush_e_s;
    assign bus.FlushM     = flush_m_s;
    assign bus.DivBusy    = div_stall_s;
    assign bus.DivDone    = div_done_r;
    assign bus.StallCount = stall_count_r;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (DIV_LATENCY=4, CNT_W=4).
module tb_pipeline_stall_ctrl;

    localparam int CNT_W = 4;

    // Flag vector order: {StallF, StallD, StallE, FlushD, FlushE, FlushM, DivBusy, DivDone}
    localparam logic [7:0] F_NONE   = 8'b0000_0000;
    localparam logic [7:0] F_LDUSE  = 8'b1100_1000;
    localparam logic [7:0] F_DIV    = 8'b1110_0110;
    localparam logic [7:0] F_DONE   = 8'b0000_0001;
    localparam logic [7:0] F_BRANCH = 8'b0001_1000;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errors  = 0;
    logic [7:0] flags_s;

    always #5 clk = ~clk;

    pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_ctrl #(
        .DIV_LATENCY(4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign flags_s = {bus.StallF, bus.StallD, bus.StallE, bus.FlushD,
                      bus.FlushE, bus.FlushM, bus.DivBusy, bus.DivDone};

    task automatic set_idle();
        bus.MemReadE = 1'b0;
        bus.RD_E     = 5'd0;
        bus.Rs1_D    = 5'd0;
        bus.Rs2_D    = 5'd0;
        bus.UseRs1D  = 1'b0;
        bus.UseRs2D  = 1'b0;
        bus.IsDivE   = 1'b0;
        bus.PCSrcE   = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2);
        set_idle();
        bus.MemReadE = 1'b1;
        bus.RD_E     = rd;
        bus.Rs1_D    = rs1;
        bus.Rs2_D    = rs2;
        bus.UseRs1D  = u1;
        bus.UseRs2D  = u2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.MemReadE = 1'($urandom);
            bus.RD_E     = 5'($urandom);
            bus.Rs1_D    = bus.RD_E;
            bus.Rs2_D    = 5'($urandom);
            bus.UseRs1D  = 1'b1;
            bus.UseRs2D  = 1'($urandom);
            bus.IsDivE   = 1'b1;
            bus.PCSrcE   = 1'($urandom);
            #1;
            vectors++;
            if (flags_s !== F_NONE) begin
                errors++;
                $display("FAIL reset_flags cyc=%0d got=%b want=%b", i, flags_s, F_NONE);
            end
            vectors++;
            if (bus.StallCount !== 4'd0) begin
                errors++;
                $display("FAIL reset_count cyc=%0d got=%0d want=0", i, bus.StallCount);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1;
            set_idle();
            #1;
            vectors++;
            if ({flags_s, bus.StallCount} !== {F_NONE, 4'd0}) begin
                errors++;
                $display("FAIL post_reset_idle cyc=%0d got=%b/%0d want=%b/0", i, flags_s, bus.StallCount, F_NONE);
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (flags_s !== F_LDUSE) begin
            errors++;
            $display("FAIL load_use_flags got=%b want=%b", flags_s, F_LDUSE);
        end
        @(negedge clk);
        set_idle();
        #1;
        vectors++;
        if ({flags_s, bus.StallCount} !== {F_NONE, 4'd1}) begin
            errors++;
            $display("FAIL load_use_clear got=%b/%0d want=%b/1", flags_s, bus.StallCount, F_NONE);
        end
        // x0 destination, unused source, and rs2 match each checked in turn
        @(negedge clk);
        set_load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        #1;
        vectors++;
        if (flags_s !== F_NONE) begin
            errors++;
            $display("FAIL load_use_x0 got=%b want=%b", flags_s, F_NONE);
        end
        @(negedge clk);
        set_load_use(5'd9, 5'd9, 5'd9, 1'b0, 1'b0);
        #1;
        vectors++;
        if (flags_s !== F_NONE) begin
            errors++;
            $display("FAIL load_use_unused got=%b want=%b", flags_s, F_NONE);
        end
        @(negedge clk);
        set_load_use(5'd12, 5'd3, 5'd12, 1'b1, 1'b1);
        #1;
        vectors++;
        if (flags_s !== F_LDUSE) begin
            errors++;
            $display("FAIL load_use_rs2 got=%b want=%b", flags_s, F_LDUSE);
        end
        @(negedge clk);
        set_idle();
        #1;
        vectors++;
        if (bus.StallCount !== 4'd2) begin
            errors++;
            $display("FAIL load_use_count got=%0d want=2", bus.StallCount);
        end
    endtask

    task automatic test_divide();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            set_idle();
            bus.IsDivE = 1'b1;
            // a load-use hazard during the divide must not change the divide controls
            if (k == 3) set_load_use(5'd4, 5'd4, 5'd0, 1'b1, 1'b0);
            if (k == 3) bus.IsDivE = 1'b1;
            #1;
            vectors++;
            if ({flags_s, bus.StallCount} !== {F_DIV, 4'(k - 1)}) begin
                errors++;
                $display("FAIL div_stall k=%0d got=%b/%0d want=%b/%0d", k, flags_s, bus.StallCount, F_DIV, k - 1);
            end
        end
        @(negedge clk);
        set_idle();
        bus.IsDivE = 1'b1;
        #1;
        vectors++;
        if ({flags_s, bus.StallCount} !== {F_DONE, 4'd4}) begin
            errors++;
            $display("FAIL div_done got=%b/%0d want=%b/4", flags_s, bus.StallCount, F_DONE);
        end
        @(negedge clk);
        set_idle();
        #1;
        vectors++;
        if ({flags_s, bus.StallCount} !== {F_NONE, 4'd4}) begin
            errors++;
            $display("FAIL div_after got=%b/%0d want=%b/4", flags_s, bus.StallCount, F_NONE);
        end
    endtask

    task automatic test_branch();
        do_reset();
        @(negedge clk);
        set_load_use(5'd7, 5'd0, 5'd7, 1'b0, 1'b1);
        bus.PCSrcE = 1'b1;
        #1;
        vectors++;
        if (flags_s !== F_BRANCH) begin
            errors++;
            $display("FAIL branch_load_use got=%b want=%b", flags_s, F_BRANCH);
        end
        @(negedge clk);
        set_idle();
        bus.PCSrcE = 1'b1;
        bus.IsDivE = 1'b1;
        #1;
        vectors++;
        if (flags_s !== F_BRANCH) begin
            errors++;
            $display("FAIL branch_div got=%b want=%b", flags_s, F_BRANCH);
        end
        @(negedge clk);
        set_idle();
        #1;
        vectors++;
        if ({flags_s, bus.StallCount} !== {F_NONE, 4'd0}) begin
            errors++;
            $display("FAIL branch_after got=%b/%0d want=%b/0", flags_s, bus.StallCount, F_NONE);
        end
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            set_idle();
            bus.IsDivE = 1'b1;
            #1;
            vectors++;
            if (flags_s !== F_DIV) begin
                errors++;
                $display("FAIL middiv_stall k=%0d got=%b want=%b", k, flags_s, F_DIV);
            end
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({flags_s, bus.StallCount} !== {F_NONE, 4'd0}) begin
            errors++;
            $display("FAIL middiv_async got=%b/%0d want=%b/0", flags_s, bus.StallCount, F_NONE);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst = 1'b1;
            set_idle();
            #1;
            vectors++;
            if ({flags_s, bus.StallCount} !== {F_NONE, 4'd0}) begin
                errors++;
                $display("FAIL middiv_after k=%0d got=%b/%0d want=%b/0", k, flags_s, bus.StallCount, F_NONE);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            set_load_use(5'd3, 5'd3, 5'd0, 1'b1, 1'b0);
            #1;
            vectors++;
            if (bus.StallCount !== 4'((i - 1) > 15 ? 15 : (i - 1))) begin
                errors++;
                $display("FAIL sat_count i=%0d got=%0d want=%0d", i, bus.StallCount, (i - 1) > 15 ? 15 : (i - 1));
            end
        end
        @(negedge clk);
        set_idle();
        #1;
        vectors++;
        if (bus.StallCount !== 4'd15) begin
            errors++;
            $display("FAIL sat_final got=%0d want=15", bus.StallCount);
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b0;
        test_reset();
        test_load_use();
        test_divide();
        test_branch();
        test_reset_mid_div();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
